port_out_writer: RTL and testbench
==================================

// Module: port_out_writer
// PURPOSE
//  Write-side counterpart of the keyboard controller's Port_ID input decoder.
//  Captures PicoBlaze OUTPUT transactions (Port_ID, Out_Port, Write_Strobe) into
//  registered destinations: a FIFO of bytes for the display writer, a control
//  register and a one-cycle command strobe. A status byte is returned to the
//  input mux so firmware can poll FIFO occupancy.
// PARAMETERS
//  FIFO_DEPTH  4      byte FIFO depth; power of two, 2..16
//  DATA_PORT   8'h05  port ID whose writes push Out_Port into the FIFO
//  CTRL_PORT   8'h06  port ID whose writes load ctrl_reg
//  CMD_PORT    8'h07  port ID whose writes fire cmd_pulse
//  CTRL_RESET  8'h00  reset value of ctrl_reg
// PORTS
//  clk           in   1  system clock, all state on rising edge
//  reset         in   1  synchronous, active-high
//  Port_ID       in   8  PicoBlaze port address
//  Out_Port      in   8  PicoBlaze write data
//  Write_Strobe  in   1  1-cycle write qualifier
//  fifo_data     out  8  FIFO head byte (first-word fall-through)
//  fifo_valid    out  1  FIFO non-empty
//  fifo_ready    in   1  consumer accepts head when fifo_valid=1
//  ctrl_reg      out  8  control register
//  cmd_pulse     out  1  1-cycle pulse per CMD_PORT write
//  cmd_data      out  8  byte of the latest CMD_PORT write
//  status        out  8  {ovf, 2'b00, full, empty, count[2:0]}; count saturates at 7
// BEHAVIOUR
//  - Reset: FIFO pointers and count = 0; fifo_valid=0; fifo_data=0; ctrl_reg=CTRL_RESET;
//    cmd_pulse=0; cmd_data=0; ovf=0; status=8'h08 (empty=1). Reset mid-operation
//    discards FIFO contents and any pending pulse.
//  - Writes are sampled only when Write_Strobe=1. Unmatched Port_IDs are ignored.
//  - Push: DATA_PORT write when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop
//    occurs in the same cycle. Pushed byte is visible on fifo_data/fifo_valid the
//    next cycle if the FIFO was empty.
//  - Pop: fifo_valid && fifo_ready; the head advances on that edge.
//  - Simultaneous push and pop: count unchanged; both pointers advance; wrap modulo
//    FIFO_DEPTH.
//  - Overflow: push refused while full without a pop; byte dropped, ovf set (sticky).
//    ovf clears on a CMD_PORT write with Out_Port[7]=1. Overflow and clear in one cycle
//    is impossible because the two writes use different ports.
//  - CTRL_PORT write: ctrl_reg <= Out_Port on the next edge (1-cycle latency).
//  - CMD_PORT write: cmd_data <= Out_Port, cmd_pulse=1 for exactly the next cycle.
//    Back-to-back writes give back-to-back pulses.
//  - status is registered and reflects state after the current edge: full=(count==DEPTH),
//    empty=(count==0).
// CONFIGURATION
//  OVF_COUNT_EN defined: adds output ovf_count[7:0]. Reset 0; increments on every
//   dropped push, saturates at 8'hFF, clears with ovf.
//  OVF_COUNT_EN undefined: port and counter absent; only the sticky ovf bit exists.
// TESTING
//  1 Reset: status=8'h08, ctrl_reg=CTRL_RESET, fifo_valid=0, cmd_pulse=0.
//  2 Fill/drain: write 8'h41,8'h42,8'h43,8'h44 to 0x05 with fifo_ready=0 -> status=8'h14;
//    raise ready -> 41,42,43,44 delivered in order, then status=8'h08.
//  3 Overflow: 5th write of 8'h45 to full FIFO -> dropped, status=8'h94; write 8'h80 to
//    0x07 -> status=8'h14 (with OVF_COUNT_EN: ovf_count 1 then 0).
//  4 Full with push+pop in same cycle: write 8'h55 while pop -> accepted, count stays 4,
//    tail byte=55.
//  5 Write 8'hA5 to 0x06 -> ctrl_reg=A5 the next cycle. Write 8'h3C to 0x07 ->
//    single-cycle cmd_pulse, cmd_data=3C. Write to 0x09 -> no state change.
//  6 Assert reset with 3 bytes queued and cmd_pulse pending -> next cycle status=8'h08,
//    cmd_pulse=0.

Source files
------------

// File: rtl/port_out_writer.sv
// port_out_writer: PicoBlaze OUTPUT-port write decoder.
// Captures Write_Strobe qualified writes into a first-word fall-through byte
// FIFO (DATA_PORT), a control register (CTRL_PORT) and a one-cycle command
// strobe with its data byte (CMD_PORT). A registered status byte
// {ovf, 2'b00, full, empty, count[2:0]} lets firmware poll FIFO occupancy.
// Optional build macro OVF_COUNT_EN adds an 8-bit saturating dropped-push
// counter output ovf_count, cleared together with ovf.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   Port_ID, Out_Port, Write_Strobe PicoBlaze output bus
//   fifo_data, fifo_valid, fifo_ready  FIFO head and handshake
//   ctrl_reg                        control register
//   cmd_pulse, cmd_data             command strobe and its byte
//   status                          occupancy/overflow byte
//   ovf_count                       dropped-push count (OVF_COUNT_EN only)
module port_out_writer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  DATA_PORT  = 8'h05,
  parameter logic [7:0]  CTRL_PORT  = 8'h06,
  parameter logic [7:0]  CMD_PORT   = 8'h07,
  parameter logic [7:0]  CTRL_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Port_ID,
  input  logic [7:0] Out_Port,
  input  logic       Write_Strobe,
  output logic [7:0] fifo_data,
  output logic       fifo_valid,
  input  logic       fifo_ready,
  output logic [7:0] ctrl_reg,
  output logic       cmd_pulse,
  output logic [7:0] cmd_data,
  output logic [7:0] status
`ifdef OVF_COUNT_EN
  ,
  output logic [7:0] ovf_count
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, rd_inc;
  logic [CW-1:0] count, count_next;
  logic          ovf, ovf_next;
  logic [7:0]    head_next;
  logic [7:0]    ctrl_next, cmd_data_next, status_next;
  logic          cmd_pulse_next;
  logic          wr_data, wr_ctrl, wr_cmd;
  logic          full, pop, push, drop, ovf_clr;
  logic [2:0]    cnt3;
  int unsigned   count_int;
`ifdef OVF_COUNT_EN
  logic [7:0]    ovf_count_next;
`endif

  // Write decode and FIFO handshake
  always_comb begin
    wr_data = Write_Strobe && (Port_ID == DATA_PORT);
    wr_ctrl = Write_Strobe && (Port_ID == CTRL_PORT);
    wr_cmd  = Write_Strobe && (Port_ID == CMD_PORT);
    full    = (count == CW'(FIFO_DEPTH));
    pop     = fifo_valid && fifo_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push    = wr_data && (!full || pop);
    drop    = wr_data && full && !pop;
    ovf_clr = wr_cmd && Out_Port[7];
    rd_inc  = rd_ptr + PW'(1);
  end

  // Next-state computation
  always_comb begin
    count_next     = count;
    wr_ptr_next    = wr_ptr;
    rd_ptr_next    = rd_ptr;
    head_next      = fifo_data;
    ovf_next       = ovf;
    ctrl_next      = ctrl_reg;
    cmd_data_next  = cmd_data;
    cmd_pulse_next = 1'b0;
    count_int      = 0;
    cnt3           = 3'd0;
    status_next    = 8'h00;
`ifdef OVF_COUNT_EN
    ovf_count_next = ovf_count;
`endif

    if (push) wr_ptr_next = wr_ptr + PW'(1);
    if (pop)  rd_ptr_next = rd_inc;
    if (push && !pop) count_next = count + CW'(1);
    if (pop && !push) count_next = count - CW'(1);

    // Head register: next slot on pop, bypass when the pushed byte lands there.
    if (pop) begin
      if (push && (wr_ptr == rd_inc)) head_next = Out_Port;
      else                            head_next = mem[rd_inc];
    end else if (push && (count == CW'(0))) begin
      head_next = Out_Port;
    end

    if (drop)         ovf_next = 1'b1;
    else if (ovf_clr) ovf_next = 1'b0;
`ifdef OVF_COUNT_EN
    if (drop) begin
      if (ovf_count != 8'hFF) ovf_count_next = ovf_count + 8'd1;
    end else if (ovf_clr) begin
      ovf_count_next = 8'h00;
    end
`endif

    if (wr_ctrl) ctrl_next = Out_Port;
    if (wr_cmd) begin
      cmd_data_next  = Out_Port;
      cmd_pulse_next = 1'b1;
    end

    count_int   = 32'(count_next);
    cnt3        = (count_int > 7) ? 3'd7 : 3'(count_int);
    status_next = {ovf_next, 2'b00, (count_next == CW'(FIFO_DEPTH)),
                   (count_next == CW'(0)), cnt3};
  end

  // FIFO storage (contents need no reset; visibility is governed by count)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Out_Port;
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_valid <= 1'b0;
      fifo_data  <= 8'h00;
      ovf        <= 1'b0;
      ctrl_reg   <= CTRL_RESET;
      cmd_pulse  <= 1'b0;
      cmd_data   <= 8'h00;
      status     <= 8'h08;
`ifdef OVF_COUNT_EN
      ovf_count  <= 8'h00;
`endif
    end else begin
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      fifo_valid <= (count_next != CW'(0));
      fifo_data  <= head_next;
      ovf        <= ovf_next;
      ctrl_reg   <= ctrl_next;
      cmd_pulse  <= cmd_pulse_next;
      cmd_data   <= cmd_data_next;
      status     <= status_next;
`ifdef OVF_COUNT_EN
      ovf_count  <= ovf_count_next;
`endif
    end
  end

endmodule

// File: tb/tb_port_out_writer.sv
// Scoreboard bench for port_out_writer: expected FIFO bytes and command
// bytes are queued at issue time and checked by independent monitors.
module tb_port_out_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Port_ID;
  logic [7:0] Out_Port;
  logic       Write_Strobe;
  logic [7:0] fifo_data;
  logic       fifo_valid;
  logic       fifo_ready;
  logic [7:0] ctrl_reg;
  logic       cmd_pulse;
  logic [7:0] cmd_data;
  logic [7:0] status;
`ifdef OVF_COUNT_EN
  logic [7:0] ovf_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] cmd_q[$];

  port_out_writer dut (
    .clk(clk), .reset(reset), .Port_ID(Port_ID), .Out_Port(Out_Port),
    .Write_Strobe(Write_Strobe), .fifo_data(fifo_data), .fifo_valid(fifo_valid),
    .fifo_ready(fifo_ready), .ctrl_reg(ctrl_reg), .cmd_pulse(cmd_pulse),
    .cmd_data(cmd_data), .status(status)
`ifdef OVF_COUNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One write cycle: inputs held through the next rising edge.
  task automatic drive(input logic [7:0] p, input logic [7:0] d);
    Port_ID = p; Out_Port = d; Write_Strobe = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    Write_Strobe = 1'b0; Port_ID = 8'h00; Out_Port = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    fifo_ready = 1'b1;
    while (fifo_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    fifo_ready = 1'b0;
    chk("drain_timeout", 32'(fifo_valid), 32'd0);
  endtask

  // FIFO monitor: every accepted head is compared with the scoreboard.
  always @(negedge clk) begin
    if (!reset && fifo_valid && fifo_ready) begin
      if (fifo_q.size() == 0) chk("fifo_unexpected", 32'(fifo_data), 32'hFFFF);
      else chk("fifo_data", 32'(fifo_data), 32'(fifo_q.pop_front()));
    end
  end

  // Command monitor: every pulse must match a queued command byte.
  always @(negedge clk) begin
    if (!reset && cmd_pulse) begin
      if (cmd_q.size() == 0) chk("cmd_unexpected", 32'(cmd_data), 32'hFFFF);
      else chk("cmd_data", 32'(cmd_data), 32'(cmd_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fifo_ready = 1'b0;
    Write_Strobe = 1'b0; Port_ID = 8'h00; Out_Port = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_status", 32'(status), 32'h08);
    chk("rst_ctrl", 32'(ctrl_reg), 32'h00);
    chk("rst_valid", 32'(fifo_valid), 32'd0);
    chk("rst_pulse", 32'(cmd_pulse), 32'd0);
    chk("rst_fifo_data", 32'(fifo_data), 32'h00);
`ifdef OVF_COUNT_EN
    chk("rst_ovf_count", 32'(ovf_count), 32'd0);
`endif

    // Fill, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(8'h05, 8'(8'h41 + i));
      fifo_q.push_back(8'(8'h41 + i));
    end
    idle();
    chk("fill_status", 32'(status), 32'h14);
    chk("fill_head", 32'(fifo_data), 32'h41);
    drain();
    chk("drain_status", 32'(status), 32'h08);

    // Refill, then overflow and clear
    for (int i = 0; i < 4; i++) begin
      drive(8'h05, 8'(8'h41 + i));
      fifo_q.push_back(8'(8'h41 + i));
    end
    drive(8'h05, 8'h45);
    idle();
    chk("ovf_status", 32'(status), 32'h94);
`ifdef OVF_COUNT_EN
    chk("ovf_count_1", 32'(ovf_count), 32'd1);
`endif
    drive(8'h07, 8'h80);
    cmd_q.push_back(8'h80);
    idle();
    chk("ovf_clr_status", 32'(status), 32'h14);
`ifdef OVF_COUNT_EN
    chk("ovf_count_0", 32'(ovf_count), 32'd0);
`endif

    // Push while full with a pop on the same edge
    fifo_ready = 1'b1;
    drive(8'h05, 8'h55);
    fifo_q.push_back(8'h55);
    fifo_ready = 1'b0;
    idle();
    chk("pushpop_status", 32'(status), 32'h14);
    chk("pushpop_head", 32'(fifo_data), 32'h42);
    drain();
    chk("pushpop_drain", 32'(status), 32'h08);

    // Push into empty then push+pop at count 1 (head bypass)
    fifo_ready = 1'b1;
    drive(8'h05, 8'h71); fifo_q.push_back(8'h71);
    drive(8'h05, 8'h72); fifo_q.push_back(8'h72);
    idle();
    drain();
    chk("bypass_status", 32'(status), 32'h08);

    // Control register, command pulse, ignored ports
    drive(8'h06, 8'hA5);
    chk("ctrl_a5", 32'(ctrl_reg), 32'hA5);
    idle();
    drive(8'h07, 8'h3C);
    cmd_q.push_back(8'h3C);
    chk("cmd_pulse_hi", 32'(cmd_pulse), 32'd1);
    chk("cmd_data_3c", 32'(cmd_data), 32'h3C);
    idle();
    chk("cmd_pulse_lo", 32'(cmd_pulse), 32'd0);
    drive(8'h07, 8'h01); cmd_q.push_back(8'h01);
    drive(8'h07, 8'h02); cmd_q.push_back(8'h02);
    chk("cmd_b2b_pulse", 32'(cmd_pulse), 32'd1);
    idle();
    drive(8'h09, 8'hFF);
    idle();
    chk("port09_ctrl", 32'(ctrl_reg), 32'hA5);
    chk("port09_status", 32'(status), 32'h08);
    chk("port09_cmd", 32'(cmd_data), 32'h02);
    Port_ID = 8'h05; Out_Port = 8'h99; Write_Strobe = 1'b0;
    @(posedge clk); #1;
    chk("nostrobe_status", 32'(status), 32'h08);

    // Reset mid-operation with bytes queued and a command in flight
    for (int i = 0; i < 3; i++) drive(8'h05, 8'(8'h31 + i));
    idle();
    chk("three_status", 32'(status), 32'h03);
    Port_ID = 8'h07; Out_Port = 8'h11; Write_Strobe = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; Write_Strobe = 1'b0;
    chk("midrst_status", 32'(status), 32'h08);
    chk("midrst_pulse", 32'(cmd_pulse), 32'd0);
    chk("midrst_valid", 32'(fifo_valid), 32'd0);
    chk("midrst_ctrl", 32'(ctrl_reg), 32'h00);
    idle();
    chk("post_rst_pulse", 32'(cmd_pulse), 32'd0);

    chk("fifo_q_empty", 32'(fifo_q.size()), 32'd0);
    chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
